pixel_stream_writer: RTL and testbench

Parametrised successor to the encrypted-image pixel generator. Accepts a stream of packed words, such as decrypted or encrypted submatrix output, over a valid/ready handshake. Unpacks each word into PIX_W-bit pixels, including pixels that straddle word boundaries, and writes them sequentially into the frame-buffer RAM feeding the VGA adapter. Emits one write per pixel, tracks the frame address, and reports frame completion. Supports restart for a new frame without reset.

---
 rtl/pixel_stream_writer_pkg.sv | 25 ++
 rtl/pixel_stream_writer_bit_unpacker.sv | 74 +++++++
 rtl/pixel_stream_writer.sv | 107 ++++++++++
 tb/tb_pixel_stream_writer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_stream_writer_pkg.sv
// Shared constants for the pixel stream writer: FSM encoding, default frame
// geometry and the sizing helpers for the unpacking bit buffer.
package pixel_stream_writer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEF_H_PIXELS     = 160;
  localparam int DEF_V_PIXELS     = 120;
  localparam int DEF_FRAME_PIXELS = DEF_H_PIXELS * DEF_V_PIXELS;
  localparam int DEF_PIX_W        = 3;
  localparam int DEF_WORD_W       = 16;
  localparam int DEF_ADDR_W       = 15;

  // Worst case: PIX_W-1 residual bits plus a freshly accepted word.
  function automatic int buf_width(input int word_w, input int pix_w);
    return word_w + pix_w - 1;
  endfunction

  function automatic int count_width(input int buf_w);
    return $clog2(buf_w + 1);
  endfunction

endpackage

// File: rtl/pixel_stream_writer_bit_unpacker.sv
// Bit buffer that absorbs packed words and releases PIX_W-bit pixels,
// carrying residual bits across word boundaries in either bit order.
module pixel_stream_writer_bit_unpacker
  import pixel_stream_writer_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int PIX_W     = DEF_PIX_W,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              run_en,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic [WORD_W-1:0] word_data,
  output logic              extract,
  output logic [PIX_W-1:0]  pix_data
);

  localparam int BUF_W = buf_width(WORD_W, PIX_W);
  localparam int CNT_W = count_width(BUF_W);

  logic [BUF_W-1:0] bits_q, bits_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [BUF_W-1:0] word_ext;
  logic [BUF_W-1:0] word_placed;
  logic [BUF_W-1:0] bits_shifted;
  logic             accept;

  assign word_ready = run_en && (count_q < CNT_W'(PIX_W));
  assign extract    = run_en && (count_q >= CNT_W'(PIX_W));
  assign accept     = word_valid && word_ready;
  assign word_ext   = BUF_W'(word_data);

  // Valid bits sit at the low end (LSB-first) or the high end (MSB-first).
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign pix_data     = bits_q[BUF_W-1 -: PIX_W];
      assign word_placed  = (word_ext << (BUF_W - WORD_W)) >> count_q;
      assign bits_shifted = bits_q << PIX_W;
    end else begin : g_lsb_first
      assign pix_data     = bits_q[PIX_W-1:0];
      assign word_placed  = word_ext << count_q;
      assign bits_shifted = bits_q >> PIX_W;
    end
  endgenerate

  always_comb begin
    bits_d  = bits_q;
    count_d = count_q;
    if (clear) begin
      bits_d  = '0;
      count_d = '0;
    end else if (accept) begin
      bits_d  = bits_q | word_placed;
      count_d = count_q + CNT_W'(WORD_W);
    end else if (extract) begin
      bits_d  = bits_shifted;
      count_d = count_q - CNT_W'(PIX_W);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bits_q  <= '0;
      count_q <= '0;
    end else begin
      bits_q  <= bits_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pixel_stream_writer.sv
// Unpacks a stream of packed words into pixels and writes them sequentially
// into the VGA frame buffer, flagging completion after the last pixel.
module pixel_stream_writer
  import pixel_stream_writer_pkg::*;
#(
  parameter int WORD_W       = DEF_WORD_W,
  parameter int PIX_W        = DEF_PIX_W,
  parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter bit MSB_FIRST    = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              frame_start,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic [WORD_W-1:0] word_data,
  output logic              write_enable,
  output logic [ADDR_W-1:0] address,
  output logic [PIX_W-1:0]  pixel,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(FRAME_PIXELS - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [PIX_W-1:0]  pixel_q, pixel_d;
  logic              write_enable_q, write_enable_d;
  logic              frame_done_q, frame_done_d;
  logic              run_en;
  logic              extract;
  logic [PIX_W-1:0]  pix_data;

  assign run_en = (state_q == ST_RUN) && enable;

  pixel_stream_writer_bit_unpacker #(
    .WORD_W    (WORD_W),
    .PIX_W     (PIX_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_unpacker (
    .clock      (clock),
    .reset      (reset),
    .clear      (frame_start),
    .run_en     (run_en),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .extract    (extract),
    .pix_data   (pix_data)
  );

  always_comb begin
    state_d        = state_q;
    index_d        = index_q;
    address_d      = address_q;
    pixel_d        = pixel_q;
    write_enable_d = 1'b0;
    frame_done_d   = frame_done_q;
    if (frame_start) begin
      state_d      = ST_RUN;
      index_d      = '0;
      frame_done_d = 1'b0;
    end else begin
      // frame_done trails the DONE transition by one edge.
      if (state_q == ST_DONE) begin
        frame_done_d = 1'b1;
      end
      if (extract) begin
        write_enable_d = 1'b1;
        address_d      = index_q;
        pixel_d        = pix_data;
        if (index_q == LAST_INDEX) begin
          state_d = ST_DONE;
        end else begin
          index_d = index_q + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      index_q        <= '0;
      address_q      <= '0;
      pixel_q        <= '0;
      write_enable_q <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      address_q      <= address_d;
      pixel_q        <= pixel_d;
      write_enable_q <= write_enable_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign write_enable = write_enable_q;
  assign address      = address_q;
  assign pixel        = pixel_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_pixel_stream_writer.sv
// Directed bench for pixel_stream_writer: LSB-first, MSB-first and a short
// 8-pixel frame instance share one stimulus bus.
module tb_pixel_stream_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        frame_start = 1'b0;
  logic        word_valid = 1'b0;
  logic [15:0] word_data = '0;

  logic        rdy_l, we_l, done_l;
  logic [14:0] addr_l;
  logic [2:0]  pix_l;
  logic        rdy_m, we_m, done_m;
  logic [14:0] addr_m;
  logic [2:0]  pix_m;
  logic        rdy_s, we_s, done_s;
  logic [14:0] addr_s;
  logic [2:0]  pix_s;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pixel_stream_writer #(.MSB_FIRST(1'b0)) dut_lsb (
    .clock(clock), .reset(reset), .enable(enable), .frame_start(frame_start),
    .word_valid(word_valid), .word_ready(rdy_l), .word_data(word_data),
    .write_enable(we_l), .address(addr_l), .pixel(pix_l), .frame_done(done_l)
  );

  pixel_stream_writer #(.MSB_FIRST(1'b1)) dut_msb (
    .clock(clock), .reset(reset), .enable(enable), .frame_start(frame_start),
    .word_valid(word_valid), .word_ready(rdy_m), .word_data(word_data),
    .write_enable(we_m), .address(addr_m), .pixel(pix_m), .frame_done(done_m)
  );

  pixel_stream_writer #(.FRAME_PIXELS(8)) dut_small (
    .clock(clock), .reset(reset), .enable(enable), .frame_start(frame_start),
    .word_valid(word_valid), .word_ready(rdy_s), .word_data(word_data),
    .write_enable(we_s), .address(addr_s), .pixel(pix_s), .frame_done(done_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic peek(input int sel, output logic we, output logic [14:0] addr,
                      output logic [2:0] pix, output logic rdy, output logic done);
    case (sel)
      1:       begin we = we_m; addr = addr_m; pix = pix_m; rdy = rdy_m; done = done_m; end
      2:       begin we = we_s; addr = addr_s; pix = pix_s; rdy = rdy_s; done = done_s; end
      default: begin we = we_l; addr = addr_l; pix = pix_l; rdy = rdy_l; done = done_l; end
    endcase
  endtask

  // All tasks start and end on a falling edge.
  task automatic frame_pulse();
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] d, input int sel);
    logic we, rdy, done;
    logic [14:0] addr;
    logic [2:0] pix;
    int n = 0;
    word_data  = d;
    word_valid = 1'b1;
    peek(sel, we, addr, pix, rdy, done);
    while (!rdy && n < 64) begin
      @(negedge clock);
      n++;
      peek(sel, we, addr, pix, rdy, done);
    end
    check_eq("handshake_in_time", (n < 64) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clock);
    word_valid = 1'b0;
    $display("word %h sent to dut %0d after %0d wait cycles", d, sel, n);
  endtask

  // exp holds pixel i in bits [3i +: 3].
  task automatic check_writes(input int sel, input int base, input int n, input logic [47:0] exp);
    logic we, rdy, done;
    logic [14:0] addr;
    logic [2:0] pix;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      peek(sel, we, addr, pix, rdy, done);
      check_eq("write_strobe", we, 1'b1);
      check_eq("write_addr", addr, base + i);
      check_eq("write_pixel", pix, exp[i*3 +: 3]);
    end
  endtask

  initial begin
    logic we, rdy, done;
    logic [14:0] addr;
    logic [2:0] pix;
    int seen, extra;

    repeat (3) @(negedge clock);
    peek(0, we, addr, pix, rdy, done);
    check_eq("rst_we", we, 0);
    check_eq("rst_addr", addr, 0);
    check_eq("rst_pixel", pix, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ready", rdy, 0);
    reset = 1'b0;
    @(negedge clock);
    peek(0, we, addr, pix, rdy, done);
    check_eq("idle_ready", rdy, 0);

    // LSB-first 0x0E4B = octal 7113 -> pixels 3,1,1,7,0
    frame_pulse();
    peek(0, we, addr, pix, rdy, done);
    check_eq("run_ready", rdy, 1);
    send_word(16'h0E4B, 0);
    peek(0, we, addr, pix, rdy, done);
    check_eq("latency_no_write", we, 0);
    check_writes(0, 0, 5, 48'o07113);
    peek(0, we, addr, pix, rdy, done);
    check_eq("ready_after_5th", rdy, 1);
    @(negedge clock);
    peek(0, we, addr, pix, rdy, done);
    check_eq("idle_gap_we", we, 0);
    check_eq("idle_gap_ready", rdy, 1);

    // Straddle: residual 0 + 0xFFFF -> 6,7,7,7,7
    send_word(16'hFFFF, 0);
    check_writes(0, 5, 5, 48'o77776);

    // MSB-first 0xE000 -> 7,0,0,0,0
    frame_pulse();
    send_word(16'hE000, 1);
    check_writes(1, 0, 5, 48'o00007);

    // 8-pixel frame, continuous valid: 0x0E4B twice -> 3,1,1,7,0,6,2,2
    frame_pulse();
    word_data  = 16'h0E4B;
    word_valid = 1'b1;
    seen = 0;
    for (int c = 0; c < 60 && seen < 8; c++) begin
      @(negedge clock);
      peek(2, we, addr, pix, rdy, done);
      if (we) begin
        check_eq("small_addr", addr, seen);
        check_eq("small_pixel", pix, (48'o22607113 >> (3*seen)) & 48'h7);
        check_eq("small_done_early", done, 0);
        seen++;
      end
    end
    check_eq("small_write_count", seen, 8);
    @(negedge clock);
    peek(2, we, addr, pix, rdy, done);
    check_eq("small_done", done, 1);
    check_eq("small_done_we", we, 0);
    check_eq("small_done_ready", rdy, 0);
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      peek(2, we, addr, pix, rdy, done);
      if (we) extra++;
    end
    check_eq("small_extra_writes", extra, 0);
    check_eq("small_ready_held_low", rdy, 0);
    check_eq("small_done_sticky", done, 1);
    word_valid = 1'b0;
    frame_pulse();
    peek(2, we, addr, pix, rdy, done);
    check_eq("restart_done_clear", done, 0);
    check_eq("restart_ready", rdy, 1);
    send_word(16'h0E4B, 2);
    check_writes(2, 0, 2, 48'o13);

    // Enable gap of three cycles after two writes
    frame_pulse();
    send_word(16'h0E4B, 0);
    check_writes(0, 0, 2, 48'o13);
    enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      peek(0, we, addr, pix, rdy, done);
      check_eq("gap_we", we, 0);
      check_eq("gap_ready", rdy, 0);
    end
    enable = 1'b1;
    check_writes(0, 2, 3, 48'o071);

    // Asynchronous reset between edges mid-frame
    frame_pulse();
    send_word(16'h0E4B, 0);
    check_writes(0, 0, 3, 48'o113);
    #2 reset = 1'b1;
    #1;
    peek(0, we, addr, pix, rdy, done);
    check_eq("async_rst_we", we, 0);
    check_eq("async_rst_addr", addr, 0);
    check_eq("async_rst_pixel", pix, 0);
    check_eq("async_rst_ready", rdy, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      peek(0, we, addr, pix, rdy, done);
      if (we) extra++;
    end
    check_eq("post_rst_writes", extra, 0);
    frame_pulse();
    send_word(16'hFFFF, 0);
    check_writes(0, 0, 5, 48'o77777);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
